// File: rtl/lvds_pkg.sv
// Shared constants for the AT86RF215 LVDS I/Q link (TX and RX sides).
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package lvds_pkg;

  // Sync markers carried in the top two bits of the I half and the Q half.
  localparam logic [1:0]  SYNC_I      = 2'b10;
  localparam logic [1:0]  SYNC_Q      = 2'b01;
  // A 32-bit frame moves as 16 two-bit DDR pairs.
  localparam int          FRAME_PAIRS = 16;
  // I = 0, Q = 0, with both sync markers already in place.
  localparam logic [31:0] ZERO_FRAME  = 32'h8000_4000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } tx_state_e;

  // Overwrite the sync marker positions of a frame.
  function automatic logic [31:0] apply_sync(input logic [31:0] w);
    logic [31:0] r;
    r          = w;
    r[31:30]   = SYNC_I;
    r[15:14]   = SYNC_Q;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one level signal crossing into clk_i.
// Latency: 2 clk_i cycles. Backpressure: none.
// Ports: clk_i, rst_ni (async active-low, output clears to 0), d_i async level in, q_o synchronized level out.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lvds_tx.sv
// LVDS I/Q transmitter: pulls 32-bit frames from the TX FIFO and sends them MSB-first as DDR pairs.
// Latency: 1 cycle from frame load to first pair on the pins; one PRIME frame of 00 precedes streaming.
// Backpressure: none toward the link; an empty FIFO at prefetch time yields a zero frame and bumps the underrun count.
// Ports: i_ddr_clk/i_rst_b clock and async active-low reset; i_tx_enable async stream enable;
//        i_fifo_empty/i_fifo_data/o_fifo_pull FIFO read side (data one cycle after pull);
//        o_ddr_data {rise bit, fall bit}; o_underrun_cnt saturating zero-fill count; o_debug_state FSM state.
module lvds_tx
  import lvds_pkg::*;
#(
  parameter int FORCE_SYNC = 1,
  parameter int UNDERRUN_W = 8
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_rst_b,
  input  logic                  i_tx_enable,
  input  logic                  i_fifo_empty,
  input  logic [31:0]           i_fifo_data,
  output logic                  o_fifo_pull,
  output logic [1:0]            o_ddr_data,
  output logic [UNDERRUN_W-1:0] o_underrun_cnt,
  output logic [1:0]            o_debug_state
);

  localparam logic [3:0] LAST_PAIR    = 4'(FRAME_PAIRS - 1);
  localparam logic [3:0] PULL_PAIR    = 4'd13;
  localparam logic [3:0] CAPTURE_PAIR = 4'd14;

  logic                  en_s;
  tx_state_e             state_q,   state_d;
  logic [3:0]            pair_q,    pair_d;
  logic [31:0]           shift_q,   shift_d;
  logic [31:0]           next_q,    next_d;
  logic                  next_vld_q, next_vld_d;
  logic                  pulled_q;
  logic [1:0]            ddr_q,     ddr_d;
  logic [UNDERRUN_W-1:0] cnt_q,     cnt_d;
  logic                  load;

  sync_2ff u_en_sync (
    .clk_i  (i_ddr_clk),
    .rst_ni (i_rst_b),
    .d_i    (i_tx_enable),
    .q_o    (en_s)
  );

  // Pull is decoded from registered state so it is high exactly during pair 13
  // and reflects the empty flag sampled in that same cycle.
  assign o_fifo_pull = (state_q != ST_IDLE) && (pair_q == PULL_PAIR) && !i_fifo_empty;

  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q + 4'd1;
    shift_d    = {shift_q[29:0], 2'b00};
    next_d     = next_q;
    next_vld_d = next_vld_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    // Registered from the pre-edge state so the last pair of a frame still
    // leaves the pins on the cycle after STREAM exits.
    ddr_d      = (state_q == ST_STREAM) ? shift_q[31:30] : 2'b00;

    if ((pair_q == CAPTURE_PAIR) && pulled_q) begin
      next_d     = i_fifo_data;
      next_vld_d = 1'b1;
    end

    if (pair_q == LAST_PAIR) begin
      unique case (state_q)
        ST_IDLE:   if (en_s) state_d = ST_PRIME;
        ST_PRIME: begin
          state_d = ST_STREAM;
          load    = 1'b1;
        end
        ST_STREAM: begin
          if (en_s) begin
            load = 1'b1;
          end else begin
            // A word prefetched for a frame that will never be sent is dropped.
            state_d    = ST_IDLE;
            next_vld_d = 1'b0;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end

    if (load) begin
      next_vld_d = 1'b0;
      if (next_vld_q) begin
        shift_d = (FORCE_SYNC != 0) ? apply_sync(next_q) : next_q;
      end else begin
        shift_d = ZERO_FRAME;
        // The PRIME-to-STREAM load is not an underrun: nothing was streaming yet.
        if ((state_q == ST_STREAM) && (cnt_q != {UNDERRUN_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= ST_IDLE;
      pair_q     <= 4'd0;
      shift_q    <= 32'd0;
      next_q     <= 32'd0;
      next_vld_q <= 1'b0;
      pulled_q   <= 1'b0;
      ddr_q      <= 2'b00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      shift_q    <= shift_d;
      next_q     <= next_d;
      next_vld_q <= next_vld_d;
      pulled_q   <= o_fifo_pull;
      ddr_q      <= ddr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ddr_data     = ddr_q;
  assign o_underrun_cnt = cnt_q;
  assign o_debug_state  = state_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Directed bench for lvds_tx with a behavioural TX FIFO and a free-running pair counter model.
// Latency: n/a. Backpressure: n/a.
module tb_lvds_tx;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        en = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_rdata = 32'd0;
  logic        fifo_pull;
  logic [1:0]  ddr;
  logic [7:0]  ucnt;
  logic [1:0]  dstate;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          cyc = 0;
  int          pull_cnt = 0;
  int          pull_empty_err = 0;
  int          pull_cyc [0:255];
  logic [3:0]  tb_pair;

  localparam logic [1:0]  S_IDLE = 2'd0, S_PRIME = 2'd1, S_STREAM = 2'd2;
  localparam logic [31:0] ZERO_FRAME = 32'h8000_4000;

  lvds_tx #(.FORCE_SYNC(1), .UNDERRUN_W(8)) dut (
    .i_ddr_clk      (clk),
    .i_rst_b        (rst_b),
    .i_tx_enable    (en),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_data    (fifo_rdata),
    .o_fifo_pull    (fifo_pull),
    .o_ddr_data     (ddr),
    .o_underrun_cnt (ucnt),
    .o_debug_state  (dstate)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO read side: data valid the cycle after a pull; every pull is logged.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pull) begin
      pull_cyc[pull_cnt[7:0]] <= cyc;
      pull_cnt <= pull_cnt + 1;
      if (rd_ptr == wr_ptr) begin
        pull_empty_err <= pull_empty_err + 1;
      end else begin
        fifo_rdata <= mem[rd_ptr[8:0]];
        rd_ptr     <= rd_ptr + 1;
      end
    end
  end

  // Reference frame position: 0 in reset, then +1 per clock, wrapping at 16.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) tb_pair <= 4'd0;
    else        tb_pair <= tb_pair + 4'd1;
  end

  function automatic logic [31:0] fsync(input logic [31:0] w);
    return {2'b10, w[29:16], 2'b01, w[13:0]};
  endfunction

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[8:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    wr_ptr = rd_ptr;
    rst_b  = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    bit found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (dstate === s) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL %s: state timeout, got %0d want %0d", nm, dstate, s);
    end
  endtask

  // Entered at the negedge of pair 0 of the frame holding exp; ends at pair 0 of the next frame.
  task automatic check_frame(input logic [31:0] exp, input string nm, input int drop_pair);
    logic [31:0] got = 32'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      got[31-2*k -: 2] = ddr;
      if (int'(tb_pair) == drop_pair) en = 1'b0;
    end
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: frame got %h want %h", nm, got, exp);
    end
  endtask

  task automatic check_val(input int got, input int want, input string nm);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic go_idle();
    en = 1'b0;
    wait_state(S_IDLE, "go_idle");
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    en    = 1'b1;
    push(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val(int'(ddr), 0, "reset_ddr");
      check_val(int'(fifo_pull), 0, "reset_pull");
      check_val(int'(ucnt), 0, "reset_cnt");
      check_val(int'(dstate), 0, "reset_state");
    end
    en     = 1'b0;
    wr_ptr = rd_ptr;
    rst_b  = 1'b1;
  endtask

  task automatic test_single_frame();
    int base;
    int bad = 0;
    base = pull_cnt;
    push(32'hA5A5_5A5A);
    en = 1'b1;
    wait_state(S_PRIME, "single_prime");
    check_val(int'(tb_pair), 0, "single_prime_pair");
    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge clk);
      if (ddr !== 2'b00) bad++;
      if (fifo_pull !== (tb_pair == 4'd13)) bad++;
    end
    check_val(bad, 0, "single_prime_out_pull");
    @(negedge clk);
    check_val(int'(dstate), int'(S_STREAM), "single_stream");
    check_val(pull_cnt - base, 1, "single_pulls");
    check_frame(fsync(32'hA5A5_5A5A), "single_data", -1);
    check_val(int'(ucnt), 1, "single_underrun1");
    check_frame(ZERO_FRAME, "single_zero", -1);
    check_val(int'(ucnt), 2, "single_underrun2");
    go_idle();
  endtask

  task automatic test_back_to_back();
    int base;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 100; i++) push({16'hF000 + 16'(i), 16'hC000 + 16'(i)});
    base = pull_cnt;
    en = 1'b1;
    wait_state(S_STREAM, "b2b_stream");
    for (int i = 0; i < 100; i++) begin
      if (i == 99) check_val(int'(ucnt), 0, "b2b_no_underrun");
      check_frame(fsync({16'hF000 + 16'(i), 16'hC000 + 16'(i)}), "b2b_frame", -1);
    end
    check_val(int'(ucnt), 1, "b2b_tail_underrun");
    check_val(pull_cnt - base, 100, "b2b_pulls");
    for (int j = 1; j < 100; j++) begin
      int a = base + j;
      int b = base + j - 1;
      if (pull_cyc[a[7:0]] - pull_cyc[b[7:0]] != 16) bad++;
    end
    check_val(bad, 0, "b2b_pull_spacing");
    go_idle();
  endtask

  task automatic test_underrun_sat();
    do_reset();
    en = 1'b1;
    wait_state(S_STREAM, "sat_stream");
    for (int j = 0; j < 300; j++) begin
      if (j == 10)  check_val(int'(ucnt), 10, "sat_cnt10");
      if (j == 255) check_val(int'(ucnt), 255, "sat_cnt255");
      check_frame(ZERO_FRAME, "sat_zero", -1);
    end
    check_val(int'(ucnt), 255, "sat_cnt_hold");
    check_val(pull_empty_err, 0, "sat_no_empty_pull");
    go_idle();
  endtask

  task automatic test_disable_mid_and_async_reset();
    logic [31:0] d [0:5];
    int base;
    int bad = 0;
    d[0] = 32'h1234_5678; d[1] = 32'h9ABC_DEF0; d[2] = 32'h0F0F_F0F0;
    d[3] = 32'h3C3C_C3C3; d[4] = 32'hFFFF_FFFF; d[5] = 32'h7777_8888;
    do_reset();
    for (int i = 0; i < 5; i++) push(d[i]);
    base = pull_cnt;
    en = 1'b1;
    wait_state(S_STREAM, "dis_stream");
    check_frame(fsync(d[0]), "dis_frame0", -1);
    check_frame(fsync(d[1]), "dis_frame1_complete", 4);
    check_val(int'(dstate), int'(S_IDLE), "dis_idle");
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ddr !== 2'b00 || fifo_pull !== 1'b0) bad++;
    end
    check_val(bad, 0, "dis_quiet");
    check_val(pull_cnt - base, 3, "dis_pulls");
    en = 1'b1;
    wait_state(S_STREAM, "dis_restream");
    // d[2] was prefetched before the stop and must not reappear.
    check_frame(fsync(d[3]), "dis_fresh_word", -1);
    while (tb_pair != 4'd7) @(negedge clk);
    check_val(int'(ddr), 3, "arst_pre_ddr");
    #2 rst_b = 1'b0;
    #1;
    check_val(int'(ddr), 0, "arst_ddr");
    check_val(int'(dstate), 0, "arst_state");
    check_val(int'(fifo_pull), 0, "arst_pull");
    repeat (3) @(negedge clk);
    wr_ptr = rd_ptr;
    push(d[5]);
    rst_b = 1'b1;
    wait_state(S_PRIME, "arst_prime");
    check_val(int'(tb_pair), 0, "arst_prime_pair");
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge clk);
      if (ddr !== 2'b00) bad++;
    end
    check_val(bad, 0, "arst_prime_quiet");
    @(negedge clk);
    check_val(int'(dstate), int'(S_STREAM), "arst_stream");
    check_frame(fsync(d[5]), "arst_first_frame", -1);
    check_val(pull_empty_err, 0, "no_empty_pull");
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun_sat();
    test_disable_mid_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
